// File: rtl/parking_meter_pkg.sv
// Shared constants, types and helpers for the parking meter.
//   secs_t      : remaining time in seconds (0..9999), binary
//   disp_mode_e : how the display behaves for a given remaining time
//   sat_add     : saturating add of a credit amount onto the remaining time
//   bin_to_bcd  : binary seconds to four packed BCD digits {th, hu, te, on}
package parking_meter_pkg;

    localparam int unsigned ADD1_S   = 60;
    localparam int unsigned ADD2_S   = 120;
    localparam int unsigned ADD3_S   = 180;
    localparam int unsigned ADD4_S   = 300;
    localparam int unsigned LOAD1_S  = 16;
    localparam int unsigned LOAD2_S  = 150;
    localparam int unsigned MAX_S    = 9999;
    localparam int unsigned STEADY_S = 180;

    typedef logic [13:0] secs_t;

    typedef enum logic [1:0] {
        DispSteady,
        DispBlink,
        DispFlash
    } disp_mode_e;

    function automatic disp_mode_e disp_mode(input secs_t t);
        if (t == '0) begin
            return DispFlash;
        end else if (t >= secs_t'(STEADY_S)) begin
            return DispSteady;
        end else begin
            return DispBlink;
        end
    endfunction

    // T + 300 never exceeds 14 bits, but the sum is formed one bit wider anyway.
    function automatic secs_t sat_add(input secs_t t, input int unsigned amt);
        logic [14:0] sum;
        sum = {1'b0, t} + 15'(amt);
        if (sum > 15'(MAX_S)) begin
            return secs_t'(MAX_S);
        end
        return sum[13:0];
    endfunction

    // Double dabble: 14-bit binary in the low bits, BCD grows in the high bits.
    function automatic logic [15:0] bin_to_bcd(input secs_t bin);
        logic [29:0] sr;
        sr = {16'd0, bin};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sr[14 + 4 * d +: 4] >= 4'd5) begin
                    sr[14 + 4 * d +: 4] = sr[14 + 4 * d +: 4] + 4'd3;
                end
            end
            sr = sr << 1;
        end
        return sr[29:14];
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
//   bcd : 4-bit BCD digit
//   seg : segments, bit6 = g .. bit0 = a, 0 = lit; non-BCD codes are blank
module seg7_decoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/parking_meter.sv
// Parking meter: button-credited countdown with a multiplexed 4-digit display.
//   clk, rst            : clock, asynchronous active-high reset
//   add1..add4          : level buttons adding 60/120/180/300 s (rising edge acts)
//   rst1, rst2          : level buttons loading 16 s / 150 s (rising edge acts)
//   led_seg             : registered active-low segments of the scanned digit
//   a1..a4              : registered active-low anodes (thousands..ones)
//   val1..val4          : BCD of remaining time (thousands..ones)
module parking_meter #(
    parameter int unsigned CLK_HZ   = 100,
    parameter int unsigned SCAN_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add1,
    input  logic       add2,
    input  logic       add3,
    input  logic       add4,
    input  logic       rst1,
    input  logic       rst2,
    output logic [6:0] led_seg,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic       a4,
    output logic [3:0] val1,
    output logic [3:0] val2,
    output logic [3:0] val3,
    output logic [3:0] val4
);

    import parking_meter_pkg::*;

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    // Button order, MSB = highest priority.
    logic [5:0]    btn, btn_q, rise;
    logic          armed_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sdiv_q, sdiv_d;
    logic [1:0]    scan_q, scan_d;
    secs_t         t_q, t_d;
    logic          tick;
    logic [15:0]   bcd;
    logic [3:0]    digit;
    logic [6:0]    seg_raw, seg_q, seg_d;
    logic [3:0]    an_raw, an_q, an_d;
    logic          blank;

    assign btn = {rst1, rst2, add4, add3, add2, add1};
    // armed_q stays low for the first cycle after reset so a button held
    // through reset release is absorbed into btn_q without firing.
    assign rise = btn & ~btn_q & {6{armed_q}};
    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= '0;
            armed_q <= 1'b0;
            presc_q <= '0;
            sdiv_q  <= '0;
            scan_q  <= '0;
            t_q     <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            btn_q   <= btn;
            armed_q <= 1'b1;
            presc_q <= presc_d;
            sdiv_q  <= sdiv_d;
            scan_q  <= scan_d;
            t_q     <= t_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        sdiv_d  = (sdiv_q == SCAN_LAST) ? '0 : sdiv_q + 1'b1;
        scan_d  = (sdiv_q == SCAN_LAST) ? scan_q + 2'd1 : scan_q;
    end

    // A button event in the same cycle as a tick swallows that tick.
    always_comb begin
        t_d = t_q;
        if (rise[5]) begin
            t_d = secs_t'(LOAD1_S);
        end else if (rise[4]) begin
            t_d = secs_t'(LOAD2_S);
        end else if (rise[3]) begin
            t_d = sat_add(t_q, ADD4_S);
        end else if (rise[2]) begin
            t_d = sat_add(t_q, ADD3_S);
        end else if (rise[1]) begin
            t_d = sat_add(t_q, ADD2_S);
        end else if (rise[0]) begin
            t_d = sat_add(t_q, ADD1_S);
        end else if (tick && t_q != '0) begin
            t_d = t_q - 1'b1;
        end
    end

    assign bcd = bin_to_bcd(t_q);

    always_comb begin
        digit  = bcd[15:12];
        an_raw = 4'b0111;
        unique case (scan_q)
            2'd0: begin digit = bcd[15:12]; an_raw = 4'b0111; end
            2'd1: begin digit = bcd[11:8];  an_raw = 4'b1011; end
            2'd2: begin digit = bcd[7:4];   an_raw = 4'b1101; end
            2'd3: begin digit = bcd[3:0];   an_raw = 4'b1110; end
        endcase
    end

    seg7_decoder u_dec (
        .bcd (digit),
        .seg (seg_raw)
    );

    always_comb begin
        unique case (disp_mode(t_q))
            DispBlink: blank = t_q[0];
            DispFlash: blank = (presc_q >= PRESC_HALF);
            default:   blank = 1'b0;
        endcase
        seg_d = blank ? 7'h7F : seg_raw;
        an_d  = blank ? 4'hF : an_raw;
    end

    assign led_seg          = seg_q;
    assign {a1, a2, a3, a4} = an_q;
    assign {val1, val2, val3, val4} = bcd;

endmodule

// File: tb/tb_parking_meter.sv
module tb_parking_meter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       add1 = 1'b0, add2 = 1'b0, add3 = 1'b0, add4 = 1'b0;
    logic       rst1 = 1'b0, rst2 = 1'b0;
    logic [6:0] led_seg;
    logic       a1, a2, a3, a4;
    logic [3:0] val1, val2, val3, val4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] amt_e[3]   = '{16'h0120, 16'h0180, 16'h0300};
    logic [15:0] after_e[3] = '{16'h0119, 16'h0179, 16'h0299};
    logic [6:0]  seg50_e[3] = '{7'h79, 7'h79, 7'h30};
    logic [6:0]  seg102_e[3] = '{7'h7F, 7'h7F, 7'h24};
    logic [3:0]  an102_e[3] = '{4'hF, 4'hF, 4'b1011};

    parking_meter #(
        .CLK_HZ   (100),
        .SCAN_DIV (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .add1    (add1),
        .add2    (add2),
        .add3    (add3),
        .add4    (add4),
        .rst1    (rst1),
        .rst2    (rst2),
        .led_seg (led_seg),
        .a1      (a1),
        .a2      (a2),
        .a3      (a3),
        .a4      (a4),
        .val1    (val1),
        .val2    (val2),
        .val3    (val3),
        .val4    (val4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {val1, val2, val3, val4};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s val observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [6:0] seg_e, input logic [3:0] an_e);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {led_seg, a1, a2, a3, a4};
        exp = {seg_e, an_e};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s seg/anodes observed %h/%b expected %h/%b",
                   tag, obs[10:4], obs[3:0], exp[10:4], exp[3:0]);
        end
    endtask

    // cyc counts rising edges since reset release; inputs change 1 ns after an edge.
    task automatic goto(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset state and zero flash
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("reset_val", 16'h0000);
        check_disp("reset_disp", 7'h7F, 4'hF);
        rst = 1'b0;
        cyc = 0;
        goto(10);  check_disp("flash_on", 7'h40, 4'b1011);
        goto(60);  check_disp("flash_off", 7'h7F, 4'hF);

        // add1, then first tick and parity blink
        goto(110); add1 = 1'b1;
        goto(111); check_val("add1", 16'h0060);
        goto(199); check_val("add1_pre_tick", 16'h0060);
        check_disp("even_shown", 7'h02, 4'b1101);
        goto(200); check_val("add1_tick", 16'h0059);
        goto(201); check_disp("odd_blank", 7'h7F, 4'hF);
        goto(210); add1 = 1'b0;

        // rst1 load, count down to zero, zero flash, rst2 load
        goto(250); rst1 = 1'b1;
        goto(251); check_val("rst1", 16'h0016);
        goto(260); rst1 = 1'b0;
        goto(1799); check_val("rst1_t1", 16'h0001);
        goto(1800); check_val("rst1_t0", 16'h0000);
        goto(1810); check_disp("zero_on", 7'h40, 4'b1011);
        goto(1860); check_disp("zero_off", 7'h7F, 4'hF);
        goto(1901); check_disp("zero_on2", 7'h40, 4'b0111);
        goto(1950); rst2 = 1'b1;
        goto(1951); check_val("rst2", 16'h0150);
        goto(1955); rst2 = 1'b0;

        // add2/add3/add4 held 100 cycles from T = 0: one event each
        for (int k = 0; k < 3; k++) begin
            pulse_reset();
            goto(10);
            if (k == 0) add2 = 1'b1;
            else if (k == 1) add3 = 1'b1;
            else add4 = 1'b1;
            goto(11);  check_val("held_add", amt_e[k]);
            goto(50);  check_disp("held_disp", seg50_e[k], 4'b1011);
            goto(102); check_disp("held_after_tick_disp", seg102_e[k], an102_e[k]);
            goto(110); check_val("held_add_end", after_e[k]);
            add2 = 1'b0; add3 = 1'b0; add4 = 1'b0;
        end

        // Saturation
        pulse_reset();
        goto(10);
        for (int i = 0; i < 40; i++) begin
            add4 = 1'b1;
            goto(cyc + 2);
            add4 = 1'b0;
            goto(cyc + 2);
        end
        check_val("sat", 16'h9999);
        add4 = 1'b1;
        goto(171); check_val("sat_more", 16'h9999);
        goto(172); add4 = 1'b0;
        goto(199); check_val("sat_pre_tick", 16'h9999);
        goto(200); check_val("sat_tick", 16'h9998);

        // Asynchronous reset at 9990 with a button held through release
        goto(1000); check_val("t9990", 16'h9990);
        add2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_val", 16'h0000);
        check_disp("async_rst_disp", 7'h7F, 4'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        goto(3);  check_val("held_at_release", 16'h0000);
        goto(10); check_disp("post_rst_on", 7'h40, 4'b1011);
        add2 = 1'b0;
        goto(60); check_disp("post_rst_off", 7'h7F, 4'hF);
        goto(70); add2 = 1'b1;
        goto(71); check_val("post_rst_add2", 16'h0120);
        add2 = 1'b0;

        // Priority, event-over-tick, steady to blink transition
        pulse_reset();
        goto(10); rst2 = 1'b1; add4 = 1'b1; add1 = 1'b1;
        goto(11); check_val("prio_rst2", 16'h0150);
        goto(12); rst2 = 1'b0; add4 = 1'b0; add1 = 1'b0;
        goto(20); rst1 = 1'b1; rst2 = 1'b1;
        goto(21); check_val("prio_rst1", 16'h0016);
        goto(22); rst1 = 1'b0; rst2 = 1'b0;
        goto(30); rst2 = 1'b1;
        goto(31); check_val("reload_150", 16'h0150);
        goto(32); rst2 = 1'b0;
        goto(99); add1 = 1'b1;
        goto(100); check_val("event_beats_tick", 16'h0210);
        goto(101); add1 = 1'b0;
        goto(3199); check_val("t180", 16'h0180);
        check_disp("t180_steady", 7'h00, 4'b1101);
        goto(3200); check_val("t179", 16'h0179);
        goto(3202); check_disp("t179_blank", 7'h7F, 4'hF);
        goto(3302); check_val("t178", 16'h0178);
        check_disp("t178_shown", 7'h79, 4'b1011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_meter.md
PARKING_METER -- requirements
Module: parking_meter

Interface
Parameters: name, default, meaning.
REQ-001 SHALL have parameter CLK_HZ, default 100, clock cycles per one-second tick.
REQ-002 SHALL have parameter SCAN_DIV, default 1, clock cycles per digit-scan step (minimum 1).
Ports: name, direction, width, meaning.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset of all state.
REQ-005 SHALL have ports add1, add2, add3, add4, input, 1 each, level buttons adding 60, 120, 180 and 300 s respectively.
REQ-006 SHALL have ports rst1 and rst2, input, 1 each, level buttons loading 16 s and 150 s respectively.
REQ-007 SHALL have port led_seg, output, 7, active-low segments, bit6=g through bit0=a.
REQ-008 SHALL have ports a1, a2, a3, a4, output, 1 each, active-low digit anodes: a1 thousands, a2 hundreds, a3 tens, a4 ones.
REQ-009 SHALL have ports val1, val2, val3, val4, output, 4 each, BCD of remaining time: val1 thousands, val4 ones.

Function
REQ-010 SHALL hold remaining time T in 0..9999 s as four BCD digits (or binary plus converter); val1..val4 always equal T in BCD.
REQ-011 SHALL register each button and act only on its rising edge, once per press regardless of hold length; pulses shorter than one clock period need not be seen.
REQ-012 SHALL, on an add edge, set T = min(T + amount, 9999), saturating at 9999, never wrapping.
REQ-013 SHALL, on an rst1 edge, load T = 16; on an rst2 edge, load T = 150.
REQ-014 SHALL resolve simultaneous edges in one cycle with priority rst1 > rst2 > add4 > add3 > add2 > add1; only the winner applies.
REQ-015 SHALL drive a free-running prescaler that emits a 1-cycle tick every CLK_HZ cycles; it is cleared only by rst.
REQ-016 SHALL, on a tick with T > 0, decrement T by 1; T = 0 holds at 0.
REQ-017 SHALL, when a button event and a tick coincide, apply the button event and drop that tick.
REQ-018 SHALL update val1..val4 in the clock cycle after the sampled edge or tick (1-cycle latency).
REQ-019 SHALL display steadily for T >= 180.
REQ-020 SHALL, for 0 < T < 180, display when T is even and blank when T is odd (2 s period, 50% duty).
REQ-021 SHALL, for T = 0, show "0000" during the first half of each prescaler period and blank during the second half (1 s period, 50% duty).
REQ-022 SHALL advance a 2-bit scan index every SCAN_DIV cycles (a1, a2, a3, a4, repeat), driving exactly one anode low with led_seg showing that digit; leading zeros are shown.
REQ-023 SHALL, while blanked, drive a1..a4 = 1 and led_seg = 7'h7F; val outputs stay valid.
REQ-024 SHALL make led_seg and a1..a4 registered, without glitches between digits.

Reset
REQ-025 SHALL, while rst = 1, hold T = 0, val1..val4 = 0, prescaler = 0, scan index = 0, button edge registers = 0, a1..a4 = 1, led_seg = 7'h7F.
REQ-026 SHALL, after rst falls, resume from T = 0 with the 1 s zero-flash; a held button at release causes no event.
REQ-027 SHALL, on rst asserted mid-count, zero T immediately and discard any pending event.

Structure
REQ-028 SHALL place ADD1_S=60, ADD2_S=120, ADD3_S=180, ADD4_S=300, LOAD1_S=16, LOAD2_S=150, MAX_S=9999 and STEADY_S=180 in shared package parking_meter_pkg.
REQ-029 SHALL use one sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low segments out, combinational; non-BCD input gives blank).

Verification (CLK_HZ=100, SCAN_DIV=1)
REQ-030 SHALL check reset then add1 edge -> val = 0,0,6,0 next cycle; after 100 cycles -> 0,0,5,9; display blinks on parity.
REQ-031 SHALL check add2, add3 and add4 edges each held 100 cycles from T = 0 -> each adds exactly once (+120, +180, +300); T >= 180 gives steady display.
REQ-032 SHALL check rst1 edge -> T = 16; 16 ticks later T = 0, then 50-cycle-on / 50-cycle-off flashing; rst2 edge -> T = 150.
REQ-033 SHALL check 40 add4 presses -> T saturates at 9999; a further add4 leaves 9999; the next tick gives 9998.
REQ-034 SHALL check rst2 then add1 (T = 210), then wait 31 ticks -> T = 179; display switches from steady to 2 s blink.
REQ-035 SHALL check rst pulse at T = 9990 -> all outputs reach reset values asynchronously, then 1 s zero-flash.
